// File: rtl/uart_pkg.sv
// Shared definitions for the uart_tx arbiter slice.
package uart_pkg;

    localparam int UART_FRAME_BITS = 10;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE      = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter signals of the uart_tx arbiter.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic               uart_write_en;
    logic [7:0]         uart_data;
    logic               uart_busy;
    logic [N_REQ-1:0]   grant;
    logic               lock_active;
    logic               timeout_pulse;

    modport master (
        output req_valid, req_data, req_last, uart_busy,
        input  req_ready, uart_write_en, uart_data,
        input  grant, lock_active, timeout_pulse
    );

    modport slave (
        input  req_valid, req_data, req_last, uart_busy,
        output req_ready, uart_write_en, uart_data,
        output grant, lock_active, timeout_pulse
    );
endinterface

// File: rtl/rr_picker.sv
// Round-robin winner search starting just after the pointer.
module rr_picker #(
    parameter int N_REQ = 2,
    localparam int IW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] win,
    output logic [IW-1:0]    win_idx,
    output logic             any
);
    logic [IW-1:0] idx;

    // Scan farthest first so the nearest valid slot after ptr overwrites.
    always_comb begin
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = IW'((int'(ptr) + k) % N_REQ);
            if (req[idx]) begin
                win_idx = idx;
                any     = 1'b1;
            end
        end
        win[win_idx] = any;
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin byte arbiter in front of a single uart_tx, with message lock.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ        = 2,
    parameter int LOCK_TIMEOUT = 1024
) (
    input logic              clk,
    input logic              rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

    arb_state_t       state, state_nx;
    logic [IW-1:0]    rr_ptr;
    logic             locked;
    logic [N_REQ-1:0] grant_q;
    logic [7:0]       data_q;
    logic [CW-1:0]    cnt;

    logic [N_REQ-1:0] elig, win;
    logic [IW-1:0]    win_idx;
    logic             any, accept, owner_valid, tmo;
    logic [7:0]       win_data;

    // While locked, grant_q doubles as the owner mask.
    assign elig        = locked ? (bus.req_valid & grant_q) : bus.req_valid;
    assign owner_valid = |(bus.req_valid & grant_q);
    assign win_data    = bus.req_data[{win_idx, 3'b000} +: 8];

    assign tmo = (LOCK_TIMEOUT != 0) && (state == IDLE) && locked
               && !owner_valid && (cnt == CW'(LOCK_TIMEOUT));

    rr_picker #(.N_REQ(N_REQ)) u_pick (
        .req     (elig),
        .ptr     (rr_ptr),
        .win     (win),
        .win_idx (win_idx),
        .any     (any)
    );

    always_comb begin
        state_nx          = state;
        accept            = 1'b0;
        bus.req_ready     = '0;
        bus.uart_write_en = 1'b0;
        unique case (state)
            IDLE: begin
                if (!bus.uart_busy && any) begin
                    accept        = 1'b1;
                    bus.req_ready = win;
                    state_nx      = ISSUE;
                end
            end
            ISSUE: begin
                bus.uart_write_en = 1'b1;
                state_nx          = WAIT_START;
            end
            WAIT_START: if (bus.uart_busy) state_nx = WAIT_DONE;
            WAIT_DONE:  if (!bus.uart_busy) state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= IW'(N_REQ - 1);
            locked  <= 1'b0;
            grant_q <= '0;
            data_q  <= 8'h00;
            cnt     <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                data_q  <= win_data;
                rr_ptr  <= win_idx;
                grant_q <= win;
                locked  <= !bus.req_last[win_idx];
                cnt     <= '0;
            end else if (tmo) begin
                locked  <= 1'b0;
                grant_q <= '0;
                cnt     <= '0;
            end else if (state == IDLE && locked) begin
                cnt <= owner_valid ? '0 : cnt + 1'b1;
            end else if (state == WAIT_DONE && !bus.uart_busy && !locked) begin
                grant_q <= '0;
            end
        end
    end

    assign bus.uart_data     = data_q;
    assign bus.grant         = grant_q;
    assign bus.lock_active   = locked;
    assign bus.timeout_pulse = tmo;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a simple uart_tx busy model.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int N     = 3;
    localparam int TMO   = 16;
    localparam int FRAME = UART_FRAME_BITS * 2;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } byte_t;

    typedef struct {
        int         req;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] exp_ready;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ext_busy = 1'b0;
    int   bcnt;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(N)) bus ();

    uart_tx_arbiter #(.N_REQ(N), .LOCK_TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // uart_tx model: busy from the cycle after write_en for one frame
    always @(posedge clk or posedge rst) begin
        if (rst) bcnt <= 0;
        else if (bus.uart_write_en && bcnt == 0) bcnt <= FRAME;
        else if (bcnt > 0) bcnt <= bcnt - 1;
    end
    assign bus.uart_busy = (bcnt != 0) || ext_busy;

    int     errors = 0;
    int     checks = 0;
    byte_t  rq[N][$];
    exp_t   exp_q[$];
    int     acc_q[$];
    exp_t   mon_e;
    logic   prev_we = 1'b0;

    logic [N-1:0] s_ready, s_grant;
    logic         s_we, s_busy, s_pulse, s_lock;
    logic [7:0]   s_data;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event did not occur within its cycle bound", name);
    endtask

    task automatic drive();
        logic [N-1:0]   v;
        logic [N-1:0]   l;
        logic [8*N-1:0] d;
        v = '0;
        l = '0;
        d = '0;
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0) begin
                v[i]         = 1'b1;
                l[i]         = rq[i][0].last;
                d[8*i +: 8]  = rq[i][0].data;
            end
        end
        bus.req_valid = v;
        bus.req_last  = l;
        bus.req_data  = d;
    endtask

    task automatic step();
        @(negedge clk);
        s_ready = bus.req_ready;
        s_grant = bus.grant;
        s_we    = bus.uart_write_en;
        s_busy  = bus.uart_busy;
        s_pulse = bus.timeout_pulse;
        s_lock  = bus.lock_active;
        s_data  = bus.uart_data;
        if (s_ready != '0)
            chk("ready_onehot",
                32'($onehot(s_ready) && ((s_ready & bus.req_valid) == s_ready)), 1);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (s_ready[i]) begin
                acc_q.push_back(i);
                if (rq[i].size() > 0) void'(rq[i].pop_front());
            end
        end
        drive();
    endtask

    task automatic wait_accept(output int who);
        int c;
        who = -1;
        c   = 0;
        while (who < 0 && c < 300) begin
            step();
            c++;
            for (int i = 0; i < N; i++) if (s_ready[i]) who = i;
        end
        if (who < 0) fail("accept_wait");
    endtask

    task automatic wait_busy(input logic lvl, input string name);
        int c;
        c = 0;
        do begin
            step();
            c++;
        end while (s_busy !== lvl && c < 200);
        if (s_busy !== lvl) fail(name);
    endtask

    function automatic logic all_done();
        logic e;
        e = (exp_q.size() == 0) && !bus.uart_busy;
        for (int i = 0; i < N; i++) if (rq[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic wait_drain();
        int c;
        c = 0;
        while (!all_done() && c < 2000) begin
            step();
            c++;
        end
        if (c >= 2000) fail("drain_wait");
        step();
        step();
    endtask

    function automatic int idx_of(input logic [N-1:0] oh);
        for (int i = 0; i < N; i++) if (oh[i]) return i;
        return -1;
    endfunction

    // Scoreboard: every write_en must match the next expected byte/owner.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.uart_write_en) begin
                chk("we_single_cycle", 32'(prev_we), 0);
                if (exp_q.size() == 0) begin
                    fail("unexpected_write");
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("tx_data", 32'(bus.uart_data), 32'(mon_e.data));
                    chk("tx_grant", 32'(bus.grant), 32'(1 << mon_e.req));
                end
            end
            prev_we = bus.uart_write_en;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[11];
        int   who, w, n;
        int   ord2[4];
        int   ord3[5];
        logic lk3[5];

        // ptr starts at 0 after the first single-requester byte
        tbl[0]  = '{3'b011, 3'b010};
        tbl[1]  = '{3'b011, 3'b001};
        tbl[2]  = '{3'b111, 3'b010};
        tbl[3]  = '{3'b111, 3'b100};
        tbl[4]  = '{3'b111, 3'b001};
        tbl[5]  = '{3'b101, 3'b100};
        tbl[6]  = '{3'b110, 3'b010};
        tbl[7]  = '{3'b100, 3'b100};
        tbl[8]  = '{3'b100, 3'b100};
        tbl[9]  = '{3'b011, 3'b001};
        tbl[10] = '{3'b110, 3'b010};
        ord2 = '{0, 1, 0, 1};
        ord3 = '{0, 1, 1, 1, 0};
        lk3  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

        drive();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", 32'(bus.uart_write_en), 0);
        chk("rst_data", 32'(bus.uart_data), 0);
        chk("rst_grant", 32'(bus.grant), 0);
        chk("rst_lock", 32'(bus.lock_active), 0);
        chk("rst_pulse", 32'(bus.timeout_pulse), 0);
        chk("rst_ready", 32'(bus.req_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // single requester, exact timing
        rq[0].push_back(byte_t'{8'hA5, 1'b1});
        exp_q.push_back(exp_t'{0, 8'hA5});
        drive();
        wait_accept(who);
        chk("t1_winner", 32'(who), 0);
        step();
        chk("t1_we_t1", 32'(s_we), 1);
        chk("t1_data_t1", 32'(s_data), 32'h A5);
        step();
        chk("t1_we_t2", 32'(s_we), 0);
        chk("t1_busy_t2", 32'(s_busy), 1);
        chk("t1_grant_t2", 32'(s_grant), 1);
        wait_drain();
        chk("t1_grant_free", 32'(bus.grant), 0);

        // table of single-byte round-robin decisions
        for (int v = 0; v < 11; v++) begin
            w = idx_of(tbl[v].exp_ready);
            for (int i = 0; i < N; i++)
                if (tbl[v].valid[i])
                    rq[i].push_back(byte_t'{8'(v * 16 + i), 1'b1});
            exp_q.push_back(exp_t'{w, 8'(v * 16 + w)});
            drive();
            wait_accept(who);
            chk($sformatf("vec%0d_ready", v), 32'(s_ready), 32'(tbl[v].exp_ready));
            for (int i = 0; i < N; i++) rq[i].delete();
            drive();
            wait_drain();
        end

        // streaming round-robin between requesters 0 and 1
        acc_q.delete();
        rq[0].push_back(byte_t'{8'hB0, 1'b1});
        rq[0].push_back(byte_t'{8'hB1, 1'b1});
        rq[1].push_back(byte_t'{8'hC0, 1'b1});
        rq[1].push_back(byte_t'{8'hC1, 1'b1});
        exp_q.push_back(exp_t'{0, 8'hB0});
        exp_q.push_back(exp_t'{1, 8'hC0});
        exp_q.push_back(exp_t'{0, 8'hB1});
        exp_q.push_back(exp_t'{1, 8'hC1});
        drive();
        wait_drain();
        chk("t2_accepts", 32'(acc_q.size()), 4);
        for (int k = 0; k < 4; k++)
            if (k < acc_q.size())
                chk($sformatf("t2_order%0d", k), 32'(acc_q[k]), 32'(ord2[k]));

        // message lock: "HI\n" from requester 1 goes out contiguously
        rq[0].push_back(byte_t'{8'h30, 1'b1});
        rq[0].push_back(byte_t'{8'h31, 1'b1});
        rq[1].push_back(byte_t'{8'h48, 1'b0});
        rq[1].push_back(byte_t'{8'h49, 1'b0});
        rq[1].push_back(byte_t'{8'h0A, 1'b1});
        exp_q.push_back(exp_t'{0, 8'h30});
        exp_q.push_back(exp_t'{1, 8'h48});
        exp_q.push_back(exp_t'{1, 8'h49});
        exp_q.push_back(exp_t'{1, 8'h0A});
        exp_q.push_back(exp_t'{0, 8'h31});
        drive();
        for (int k = 0; k < 5; k++) begin
            wait_accept(who);
            chk($sformatf("t3_who%0d", k), 32'(who), 32'(ord3[k]));
            chk($sformatf("t3_lock%0d", k), 32'(s_lock), 32'(lk3[k]));
        end
        wait_drain();
        chk("t3_lock_end", 32'(bus.lock_active), 0);

        // lock timeout releases a stalled owner
        rq[0].push_back(byte_t'{8'h55, 1'b0});
        exp_q.push_back(exp_t'{0, 8'h55});
        exp_q.push_back(exp_t'{1, 8'h66});
        drive();
        wait_accept(who);
        chk("t4_owner", 32'(who), 0);
        rq[1].push_back(byte_t'{8'h66, 1'b1});
        drive();
        wait_busy(1'b1, "t4_busy_rise");
        wait_busy(1'b0, "t4_busy_fall");
        n = 0;
        do begin
            step();
            n++;
        end while (!s_pulse && n < 100);
        chk("t4_pulse_delay", 32'(n), 17);
        chk("t4_lock_at_pulse", 32'(s_lock), 1);
        step();
        chk("t4_pulse_width", 32'(s_pulse), 0);
        chk("t4_next_ready", 32'(s_ready), 32'b010);
        chk("t4_lock_clear", 32'(s_lock), 0);
        chk("t4_grant_clear", 32'(s_grant), 0);
        wait_drain();

        // reset during WAIT_DONE
        rq[0].push_back(byte_t'{8'h77, 1'b1});
        exp_q.push_back(exp_t'{0, 8'h77});
        drive();
        wait_accept(who);
        wait_busy(1'b1, "t5_busy_rise");
        repeat (3) step();
        #2;
        rst = 1'b1;
        #1;
        chk("t5_we", 32'(bus.uart_write_en), 0);
        chk("t5_data", 32'(bus.uart_data), 0);
        chk("t5_grant", 32'(bus.grant), 0);
        chk("t5_lock", 32'(bus.lock_active), 0);
        chk("t5_ready", 32'(bus.req_ready), 0);
        chk("t5_state", 32'(dut.state), 32'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rq[0].push_back(byte_t'{8'h80, 1'b1});
        rq[1].push_back(byte_t'{8'h81, 1'b1});
        exp_q.push_back(exp_t'{0, 8'h80});
        exp_q.push_back(exp_t'{1, 8'h81});
        drive();
        wait_accept(who);
        chk("t5_first_after_rst", 32'(who), 0);
        wait_accept(who);
        chk("t5_second_after_rst", 32'(who), 1);
        wait_drain();

        // valid withdrawn while busy, then a wait on external busy
        ext_busy = 1'b1;
        rq[2].push_back(byte_t'{8'h99, 1'b1});
        drive();
        step();
        chk("t6_ready_pulse", 32'(s_ready), 0);
        rq[2].delete();
        drive();
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t6_no_ready", 32'(s_ready), 0);
            chk("t6_no_we", 32'(s_we), 0);
        end
        rq[0].push_back(byte_t'{8'hA0, 1'b1});
        exp_q.push_back(exp_t'{0, 8'hA0});
        drive();
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t6_busy_hold", 32'(s_ready), 0);
        end
        ext_busy = 1'b0;
        wait_accept(who);
        chk("t6_after_busy", 32'(who), 0);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
